// File: rtl/array_stream_reader.sv
// Snapshots a packed element array on start and streams it out one element per
// valid/ready handshake. Optional zero-skipping is enabled by ARRAY_READER_SKIP_ZERO_EN.
module array_stream_reader #(
    parameter int ELEMENTS = 16,
    parameter int WIDTH    = 32,
    localparam int IDX_W   = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [ELEMENTS-1:0][WIDTH-1:0]   array,
    input  logic                             start,
    input  logic                             abort,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_element,
    output logic [IDX_W-1:0]                 out_index,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [ELEMENTS-1:0][WIDTH-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [WIDTH-1:0]               elem_q, elem_d;
    logic                           last_q, last_d;
    logic                           valid_q, valid_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;

    logic                           first_found_s;
    logic [IDX_W-1:0]               first_idx_s;
    logic                           first_last_s;
    logic [IDX_W-1:0]               next_idx_s;
    logic                           next_last_s;

`ifdef ARRAY_READER_SKIP_ZERO_EN
    // Lowest nonzero index at or above lo; MSB of the result flags a hit.
    function automatic logic [IDX_W:0] find_nz(input logic [ELEMENTS-1:0][WIDTH-1:0] arr,
                                               input logic [IDX_W:0] lo);
        logic [IDX_W:0] res;
        res = {(IDX_W+1){1'b0}};
        for (int i = ELEMENTS - 1; i >= 0; i--) begin
            if ((i >= int'(lo)) && (arr[i] != {WIDTH{1'b0}})) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    logic [IDX_W:0] first_s, after_first_s, next_s, after_next_s;

    // Priority lookups for the first element of a new stream and the successor of idx.
    always_comb begin
        first_s       = find_nz(array, {(IDX_W+1){1'b0}});
        after_first_s = find_nz(array, {1'b0, first_s[IDX_W-1:0]} + (IDX_W+1)'(1));
        next_s        = find_nz(snap_q, {1'b0, idx_q} + (IDX_W+1)'(1));
        after_next_s  = find_nz(snap_q, {1'b0, next_s[IDX_W-1:0]} + (IDX_W+1)'(1));
        first_found_s = first_s[IDX_W];
        first_idx_s   = first_s[IDX_W-1:0];
        first_last_s  = ~after_first_s[IDX_W];
        next_idx_s    = next_s[IDX_W-1:0];
        next_last_s   = ~after_next_s[IDX_W];
    end
`else
    // Dense streaming: indices simply run 0..ELEMENTS-1.
    always_comb begin
        first_found_s = 1'b1;
        first_idx_s   = {IDX_W{1'b0}};
        first_last_s  = (ELEMENTS == 1);
        next_idx_s    = idx_q + IDX_W'(1);
        next_last_s   = (next_idx_s == IDX_W'(ELEMENTS - 1));
    end
`endif

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        elem_d  = elem_q;
        last_d  = last_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d = array;
                    busy_d = 1'b1;
                    if (first_found_s) begin
                        state_d = ST_STREAM;
                        idx_d   = first_idx_s;
                        elem_d  = array[first_idx_s];
                        last_d  = first_last_s;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (out_ready && last_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                end else if (out_ready) begin
                    idx_d   = next_idx_s;
                    elem_d  = snap_q[next_idx_s];
                    last_d  = next_last_s;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, snapshot and registered output flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            snap_q  <= {(ELEMENTS*WIDTH){1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            elem_q  <= {WIDTH{1'b0}};
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            elem_q  <= elem_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_element = elem_q;
    assign out_index   = idx_q;
    assign out_last    = last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_array_stream_reader.sv
// Directed self-checking bench for array_stream_reader (4-element and 1-element instances).
module tb_array_stream_reader;

    logic              clock;
    logic              reset_n;

    logic [3:0][7:0]   arr4;
    logic              start4, abort4, ready4;
    logic              valid4, last4, busy4, done4;
    logic [7:0]        elem4;
    logic [1:0]        idx4;

    logic [0:0][7:0]   arr1;
    logic              start1, abort1, ready1;
    logic              valid1, last1, busy1, done1;
    logic [7:0]        elem1;
    logic [0:0]        idx1;

    int n_pass;
    int n_total;

    array_stream_reader #(.ELEMENTS(4), .WIDTH(8)) u4 (
        .clock(clock), .reset_n(reset_n), .array(arr4), .start(start4), .abort(abort4),
        .out_valid(valid4), .out_ready(ready4), .out_element(elem4), .out_index(idx4),
        .out_last(last4), .busy(busy4), .done(done4)
    );

    array_stream_reader #(.ELEMENTS(1), .WIDTH(8)) u1 (
        .clock(clock), .reset_n(reset_n), .array(arr1), .start(start1), .abort(abort1),
        .out_valid(valid1), .out_ready(ready1), .out_element(elem1), .out_index(idx1),
        .out_last(last1), .busy(busy1), .done(done1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int beat;
        logic [7:0] zexp [4];
        zexp = '{8'd5, 8'd0, 8'd7, 8'd0};
        n_pass = 0;
        n_total = 0;
        reset_n = 1'b0;
        arr4 = {8'd4, 8'd3, 8'd2, 8'd1};
        start4 = 1'b1; abort4 = 1'b0; ready4 = 1'b0;
        arr1 = 8'hA5;
        start1 = 1'b1; abort1 = 1'b0; ready1 = 1'b0;

        // reset held with start asserted
        repeat (3) tick();
        check("rst_valid", 32'(valid4), 32'd0);
        check("rst_busy",  32'(busy4),  32'd0);
        check("rst_done",  32'(done4),  32'd0);
        check("rst_idx",   32'(idx4),   32'd0);
        check("rst_elem",  32'(elem4),  32'd0);
        check("rst_last",  32'(last4),  32'd0);
        check("rst_valid1", 32'(valid1), 32'd0);
        start4 = 1'b0; start1 = 1'b0;
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_rst_valid", 32'(valid4), 32'd0);
        check("post_rst_busy",  32'(busy4),  32'd0);

        // full-speed stream; start held across final transfer and DONE
        ready4 = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("fs_valid", 32'(valid4), 32'd1);
            check("fs_idx",   32'(idx4),   32'(k));
            check("fs_elem",  32'(elem4),  32'(k + 1));
            check("fs_last",  32'(last4),  32'(k == 3));
            check("fs_busy",  32'(busy4),  32'd1);
            check("fs_done",  32'(done4),  32'd0);
            if (k == 3) start4 = 1'b1;
            tick();
        end
        check("fs_done_pulse", 32'(done4),  32'd1);
        check("fs_done_valid", 32'(valid4), 32'd0);
        check("fs_done_busy",  32'(busy4),  32'd1);
        tick();
        check("fs_idle_done",  32'(done4),  32'd0);
        check("fs_idle_valid", 32'(valid4), 32'd0);
        check("fs_idle_busy",  32'(busy4),  32'd0);
        start4 = 1'b0;
        tick();
        check("no_restart_valid", 32'(valid4), 32'd0);

        // stalls plus array change after the snapshot
        ready4 = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        arr4 = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        beat = 0;
        for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
            ready4 = ((cyc % 3) == 0);
            check("st_valid", 32'(valid4), 32'd1);
            check("st_idx",   32'(idx4),   32'(beat));
            check("st_elem",  32'(elem4),  32'(beat + 1));
            check("st_last",  32'(last4),  32'(beat == 3));
            if (ready4 && valid4) beat++;
            tick();
        end
        check("st_beats", 32'(beat), 32'd4);
        check("st_done",  32'(done4), 32'd1);
        tick();

        // start ignored mid-stream, abort at idx 2, then restart
        arr4 = {8'd4, 8'd3, 8'd2, 8'd1};
        ready4 = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("ab_idx0", 32'(idx4), 32'd0);
        tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("ab_start_ignored", 32'(idx4), 32'd2);
        abort4 = 1'b1;
        tick();
        abort4 = 1'b0;
        check("ab_valid", 32'(valid4), 32'd0);
        check("ab_done",  32'(done4),  32'd0);
        check("ab_busy",  32'(busy4),  32'd0);
        tick();
        check("ab_no_done", 32'(done4), 32'd0);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("rs_valid", 32'(valid4), 32'd1);
        check("rs_idx",   32'(idx4),   32'd0);
        check("rs_elem",  32'(elem4),  32'd1);
        repeat (4) tick();
        check("rs_done", 32'(done4), 32'd1);
        tick();

        // asynchronous reset mid-stream
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("ar_valid", 32'(valid4), 32'd0);
        check("ar_busy",  32'(busy4),  32'd0);
        check("ar_idx",   32'(idx4),   32'd0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check("ar_idle_valid", 32'(valid4), 32'd0);
        check("ar_idle_done",  32'(done4),  32'd0);

        // single-element instance
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("e1_valid", 32'(valid1), 32'd1);
        check("e1_idx",   32'(idx1),   32'd0);
        check("e1_elem",  32'(elem1),  32'hA5);
        check("e1_last",  32'(last1),  32'd1);
        tick();
        check("e1_hold_valid", 32'(valid1), 32'd1);
        check("e1_hold_elem",  32'(elem1),  32'hA5);
        ready1 = 1'b1;
        tick();
        check("e1_done",  32'(done1),  32'd1);
        check("e1_valid0", 32'(valid1), 32'd0);
        tick();
        check("e1_done0", 32'(done1), 32'd0);
        check("e1_busy0", 32'(busy1), 32'd0);

        // sparse array {0,7,0,5}
        ready4 = 1'b1;
        arr4 = {8'd0, 8'd7, 8'd0, 8'd5};
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
`ifdef ARRAY_READER_SKIP_ZERO_EN
        check("sz_idx0",  32'(idx4),  32'd0);
        check("sz_elem0", 32'(elem4), 32'd5);
        check("sz_last0", 32'(last4), 32'd0);
        tick();
        check("sz_idx1",  32'(idx4),  32'd2);
        check("sz_elem1", 32'(elem4), 32'd7);
        check("sz_last1", 32'(last4), 32'd1);
        tick();
        check("sz_done", 32'(done4), 32'd1);
        tick();
        arr4 = {8'd0, 8'd0, 8'd0, 8'd0};
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("zz_valid", 32'(valid4), 32'd0);
        check("zz_done",  32'(done4),  32'd1);
        check("zz_busy",  32'(busy4),  32'd1);
        tick();
        check("zz_valid2", 32'(valid4), 32'd0);
        check("zz_done2",  32'(done4),  32'd0);
        check("zz_busy2",  32'(busy4),  32'd0);
`else
        for (int k = 0; k < 4; k++) begin
            check("zd_valid", 32'(valid4), 32'd1);
            check("zd_idx",   32'(idx4),   32'(k));
            check("zd_elem",  32'(elem4),  32'(zexp[k]));
            check("zd_last",  32'(last4),  32'(k == 3));
            tick();
        end
        check("zd_done", 32'(done4), 32'd1);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
